// File: rtl/pipelined_alu_unit.sv
// rtl/pipelined_alu_unit.sv - registered EXE-stage ALU with handshakes, NZCV status register and iterative MUL
//
// Purpose: one operation in flight at a time. Single-cycle ops finish at the accept
// edge; MUL runs a shift-add loop for WIDTH cycles. The result is held in DONE until
// the consumer takes it, and only then are the flags committed to status_reg.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operation handshake (in_ready only in IDLE)
//   val1, val2        WIDTH-bit operands
//   exe_cmd           4-bit operation code
//   s_upd             commit this op's flags to status_reg on completion
//   out_valid/out_ready result handshake
//   alu_res           registered result
//   status_bits       {N,Z,C,V} of alu_res
//   status_reg        committed {N,Z,C,V}; C feeds ADC/SBC
//   busy              high while the multiply loop runs
module pipelined_alu_unit #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic [3:0]       exe_cmd,
  input  logic             s_upd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic [3:0]       status_bits,
  output logic [3:0]       status_reg,
  output logic             busy
);

  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  typedef enum logic [1:0] {IDLE, MUL_RUN, DONE} state_t;

  state_t state_q, state_d;

  logic             started_q;   // low during reset, so in_ready stays low until the first edge after release
  logic             s_upd_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] alu_res_q;
  logic [3:0]       status_bits_q;
  logic [3:0]       status_reg_q;

  logic             accept;
  logic             is_mul;
  logic             mul_last;
  logic [WIDTH:0]   ext;
  logic             c_flag;
  logic             v_flag;
  logic [WIDTH-1:0] res_d;
  logic [3:0]       flags_d;
  logic             c_in;

  assign c_in     = status_reg_q[1];
  assign is_mul   = MUL_EN && (exe_cmd == CMD_MUL);
  assign accept   = in_valid && in_ready;
  assign mul_last = (count_q == CW'(WIDTH - 1));

  // Single-cycle datapath; arithmetic is done one bit wider so bit WIDTH is carry/borrow.
  always_comb begin
    ext    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (exe_cmd)
      CMD_MOV: ext = {1'b0, val2};
      CMD_MVN: ext = {1'b0, ~val2};
      CMD_ADD: begin
        ext    = {1'b0, val1} + {1'b0, val2};
        c_flag = ext[WIDTH];
        v_flag = (val1[MSB] == val2[MSB]) && (ext[MSB] != val1[MSB]);
      end
      CMD_ADC: begin
        ext    = {1'b0, val1} + {1'b0, val2} + {{WIDTH{1'b0}}, c_in};
        c_flag = ext[WIDTH];
        v_flag = (val1[MSB] == val2[MSB]) && (ext[MSB] != val1[MSB]);
      end
      CMD_SUB: begin
        ext    = {1'b0, val1} - {1'b0, val2};
        c_flag = ext[WIDTH];
        v_flag = (val1[MSB] != val2[MSB]) && (ext[MSB] != val1[MSB]);
      end
      CMD_SBC: begin
        ext    = {1'b0, val1} - {1'b0, val2} - {{WIDTH{1'b0}}, ~c_in};
        c_flag = ext[WIDTH];
        v_flag = (val1[MSB] != val2[MSB]) && (ext[MSB] != val1[MSB]);
      end
      CMD_AND: ext = {1'b0, val1 & val2};
      CMD_ORR: ext = {1'b0, val1 | val2};
      CMD_EOR: ext = {1'b0, val1 ^ val2};
      default: ext = '0;
    endcase
    res_d   = ext[WIDTH-1:0];
    flags_d = {res_d[MSB], (res_d == '0), c_flag, v_flag};
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_mul ? MUL_RUN : DONE;
      MUL_RUN: if (mul_last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == IDLE) && started_q;
    out_valid = (state_q == DONE);
    busy      = (state_q == MUL_RUN);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_q     <= 1'b0;
      s_upd_q       <= 1'b0;
      count_q       <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
      acc_q         <= '0;
      alu_res_q     <= '0;
      status_bits_q <= '0;
      status_reg_q  <= '0;
    end else begin
      started_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            s_upd_q <= s_upd;
            if (is_mul) begin
              mcand_q  <= val1;
              mplier_q <= val2;
              acc_q    <= '0;
              count_q  <= '0;
            end else begin
              alu_res_q     <= res_d;
              status_bits_q <= flags_d;
            end
          end
        end
        MUL_RUN: begin
          acc_q    <= acc_next;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          // The product only reaches alu_res on the last step.
          if (mul_last) begin
            alu_res_q     <= acc_next;
            status_bits_q <= {acc_next[MSB], (acc_next == '0), 2'b00};
          end
        end
        DONE: begin
          if (out_ready && s_upd_q) status_reg_q <= status_bits_q;
        end
        default: ;
      endcase
    end
  end

  assign alu_res     = alu_res_q;
  assign status_bits = status_bits_q;
  assign status_reg  = status_reg_q;

endmodule

// File: tb/tb_pipelined_alu_unit.sv
// tb/tb_pipelined_alu_unit.sv - directed self-checking bench for pipelined_alu_unit
module tb_pipelined_alu_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] val1;
  logic [31:0] val2;
  logic [3:0]  exe_cmd;
  logic        s_upd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_res;
  logic [3:0]  status_bits;
  logic [3:0]  status_reg;
  logic        busy;

  int n_checks = 0;
  int n_fails  = 0;
  logic [3:0] exp_sreg = 4'b0000;

  always #5 clk = ~clk;

  pipelined_alu_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .val1        (val1),
    .val2        (val2),
    .exe_cmd     (exe_cmd),
    .s_upd       (s_upd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_res     (alu_res),
    .status_bits (status_bits),
    .status_reg  (status_reg),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_eq({tag, " in_ready"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] b, input logic supd, input logic [31:0] exp_res,
                        input logic [3:0] exp_bits, input int exp_lat);
    int lat = 0;
    bit rdy_seen = 0;
    wait_ready(tag);
    exe_cmd = cmd; val1 = a; val2 = b; s_upd = supd; in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after accept; they must not affect the in-flight op.
    in_valid = 1'b0; val1 = ~a; val2 = ~b; s_upd = ~supd; exe_cmd = 4'hF;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_seen = 1;
    end while (!out_valid && lat < 100);
    check_eq({tag, " latency"}, lat, exp_lat);
    check_eq({tag, " in_ready low while busy"}, rdy_seen, 0);
    check_eq({tag, " alu_res"}, alu_res, exp_res);
    check_eq({tag, " status_bits"}, status_bits, exp_bits);
    if (supd) exp_sreg = exp_bits;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq({tag, " out_valid dropped"}, out_valid, 0);
    check_eq({tag, " status_reg"}, status_reg, exp_sreg);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int seen;
    logic [31:0] held;
    rst = 1'b0; in_valid = 1'b0; val1 = '0; val2 = '0; exe_cmd = '0; s_upd = 1'b0; out_ready = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("reset in_ready", in_ready, 0);
    check_eq("reset out_valid", out_valid, 0);
    check_eq("reset alu_res", alu_res, 0);
    check_eq("reset status_bits", status_bits, 0);
    check_eq("reset status_reg", status_reg, 0);
    check_eq("reset busy", busy, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("in_ready after release", in_ready, 1);

    run_op("MOV", 4'b0001, 32'h1234_5678, 32'h8000_0000, 1'b1, 32'h8000_0000, 4'b1000, 1);

    // Reset in the middle of a multiply
    @(negedge clk);
    wait_ready("MUL rst");
    exe_cmd = 4'b1010; val1 = 32'd7; val2 = 32'd9; s_upd = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("mid-MUL busy", busy, 1);
    rst = 1'b0;
    #1;
    check_eq("mid-MUL rst busy", busy, 0);
    check_eq("mid-MUL rst alu_res", alu_res, 0);
    check_eq("mid-MUL rst status_bits", status_bits, 0);
    check_eq("mid-MUL rst status_reg", status_reg, 0);
    check_eq("mid-MUL rst in_ready", in_ready, 0);
    check_eq("mid-MUL rst out_valid", out_valid, 0);
    exp_sreg = 4'b0000;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post-rst in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("post-rst no stale result", seen, 0);

    run_op("ADD carry",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0000, 4'b0110, 1);
    run_op("ADC cin",    4'b0011, 32'd5,         32'd3,         1'b0, 32'd9,         4'b0000, 1);
    run_op("SBC c1",     4'b0101, 32'd10,        32'd3,         1'b1, 32'd7,         4'b0000, 1);
    run_op("SBC c0",     4'b0101, 32'd3,         32'd3,         1'b0, 32'hFFFF_FFFF, 4'b1010, 1);
    run_op("SUB ovf",    4'b0100, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 4'b0001, 1);
    run_op("SUB zero",   4'b0100, 32'd5,         32'd5,         1'b0, 32'h0000_0000, 4'b0100, 1);
    run_op("ADD ovf",    4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 4'b1001, 1);
    run_op("MVN",        4'b1001, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 4'b1000, 1);
    run_op("AND",        4'b0110, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'h0F00_0F00, 4'b0000, 1);
    run_op("ORR",        4'b0111, 32'hFF00_FF00, 32'h0F0F_0F0F, 1'b0, 32'hFF0F_FF0F, 4'b1000, 1);
    run_op("unsupported",4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0000_0000, 4'b0100, 1);
    run_op("MUL",        4'b1010, 32'h0001_0003, 32'h0000_0005, 1'b0, 32'h0005_000F, 4'b0000, 33);
    run_op("MUL wrap",   4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 4'b0000, 33);

    // Backpressure on an EOR result
    @(negedge clk);
    wait_ready("EOR");
    exe_cmd = 4'b1000; val1 = 32'hF0F0_F0F0; val2 = 32'hFF00_FF00; s_upd = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("EOR out_valid", out_valid, 1);
    check_eq("EOR alu_res", alu_res, 32'h0FF0_0FF0);
    held = 32'h0FF0_0FF0;
    exe_cmd = 4'b0010; val1 = 32'd1; val2 = 32'd2; s_upd = 1'b1; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (alu_res !== held || in_ready !== 1'b0 || out_valid !== 1'b1 || status_bits !== 4'b0000) seen++;
    end
    check_eq("backpressure hold", seen, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_eq("backpressure one handshake", out_valid, 0);
    check_eq("backpressure back to IDLE", in_ready, 1);
    check_eq("backpressure status_reg", status_reg, exp_sreg);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("ignored in_valid not executed", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
